// File: rtl/simmem_burst_beat_gen.sv
// AXI burst beat generator: expands one FIXED/INCR/WRAP address request into a
// registered per-beat stream of byte addresses, with single-beat error bursts.
module simmem_burst_beat_gen #(
    parameter int AddrW        = 19,
    parameter int IdW          = 2,
    parameter int LenW         = 8,
    parameter int SizeW        = 3,
    parameter int MaxSizeField = 2,
    parameter int BoundaryW    = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IdW-1:0]   in_id_i,
    input  logic [AddrW-1:0] in_addr_i,
    input  logic [LenW-1:0]  in_len_i,
    input  logic [SizeW-1:0] in_size_i,
    input  logic [1:0]       in_burst_i,
    output logic             beat_valid_o,
    input  logic             beat_ready_i,
    output logic [IdW-1:0]   beat_id_o,
    output logic [AddrW-1:0] beat_addr_o,
    output logic [LenW-1:0]  beat_idx_o,
    output logic             beat_last_o,
    output logic             beat_err_o
);
    localparam int AW1 = AddrW + 1;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t state_q, state_d;

    logic             accept;
    logic             beat_hs;

    logic [LenW-1:0]  len_q;
    logic [SizeW-1:0] size_q;
    logic [1:0]       burst_q;
    logic [AddrW-1:0] wrap_lower_q;
    logic [AW1-1:0]   wrap_end_q;

    assign in_ready_o   = (state_q == IDLE);
    assign beat_valid_o = (state_q == BURST);
    assign accept       = in_valid_i & in_ready_o;
    assign beat_hs      = beat_valid_o & beat_ready_i;

    // Request decode: burst geometry and legality, evaluated on the live inputs.
    logic [AW1-1:0] req_addr_x;
    logic [AW1-1:0] req_size_mask;
    logic [AW1-1:0] req_aligned_x;
    logic [AW1-1:0] req_total_x;
    logic [AW1-1:0] req_end_x;
    logic [AW1-1:0] req_wrap_lower_x;
    logic           req_wrap_len_ok;
    logic           req_err;

    always_comb begin
        req_addr_x       = {1'b0, in_addr_i};
        req_size_mask    = (AW1'(1) << in_size_i) - AW1'(1);
        req_aligned_x    = req_addr_x & ~req_size_mask;
        req_total_x      = (AW1'(in_len_i) + AW1'(1)) << in_size_i;
        req_end_x        = req_aligned_x + req_total_x - AW1'(1);
        req_wrap_lower_x = req_addr_x & ~(req_total_x - AW1'(1));
        req_wrap_len_ok  = (in_len_i == LenW'(1)) || (in_len_i == LenW'(3)) ||
                           (in_len_i == LenW'(7)) || (in_len_i == LenW'(15));

        req_err = 1'b0;
        if (in_burst_i == BURST_RSVD)
            req_err = 1'b1;
        if (in_size_i > SizeW'(MaxSizeField))
            req_err = 1'b1;
        if ((in_burst_i == BURST_WRAP) &&
            (!req_wrap_len_ok || ((req_addr_x & req_size_mask) != '0)))
            req_err = 1'b1;
        if ((in_burst_i == BURST_FIXED) && (in_len_i > LenW'(15)))
            req_err = 1'b1;
        // An overflow past the top of memory also flips the high bits, so it is
        // caught here as a boundary crossing.
        if ((in_burst_i == BURST_INCR) &&
            (((req_aligned_x ^ req_end_x) >> BoundaryW) != '0))
            req_err = 1'b1;
    end

    // Next-beat address from the currently presented beat.
    logic [AW1-1:0]   step_x;
    logic [AW1-1:0]   cur_x;
    logic [AW1-1:0]   cur_aligned_x;
    logic [AW1-1:0]   wrap_next_x;
    logic [AddrW-1:0] next_addr;
    logic [LenW-1:0]  next_idx;

    always_comb begin
        step_x        = AW1'(1) << size_q;
        cur_x         = {1'b0, beat_addr_o};
        cur_aligned_x = cur_x & ~(step_x - AW1'(1));
        wrap_next_x   = cur_x + step_x;
        next_idx      = beat_idx_o + LenW'(1);
        next_addr     = beat_addr_o;
        case (burst_q)
            BURST_INCR: next_addr = AddrW'(cur_aligned_x + step_x);
            BURST_WRAP: next_addr = (wrap_next_x == wrap_end_q) ? wrap_lower_q
                                                                : AddrW'(wrap_next_x);
            default:    next_addr = beat_addr_o;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = BURST;
            BURST:   if (beat_hs && beat_last_o) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat registers: loaded on accept, advanced on every non-final handshake.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            beat_id_o    <= '0;
            beat_addr_o  <= '0;
            beat_idx_o   <= '0;
            beat_last_o  <= 1'b0;
            beat_err_o   <= 1'b0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            wrap_lower_q <= '0;
            wrap_end_q   <= '0;
        end else if (accept) begin
            beat_id_o    <= in_id_i;
            beat_addr_o  <= in_addr_i;
            beat_idx_o   <= '0;
            beat_last_o  <= req_err || (in_len_i == '0);
            beat_err_o   <= req_err;
            len_q        <= in_len_i;
            size_q       <= in_size_i;
            burst_q      <= in_burst_i;
            wrap_lower_q <= AddrW'(req_wrap_lower_x);
            wrap_end_q   <= req_wrap_lower_x + req_total_x;
        end else if (beat_hs && !beat_last_o) begin
            beat_addr_o  <= next_addr;
            beat_idx_o   <= next_idx;
            beat_last_o  <= (next_idx == len_q);
        end
    end

endmodule

// File: tb/tb_simmem_burst_beat_gen.sv
// Bench for simmem_burst_beat_gen: directed test-plan bursts, reset mid-burst,
// then randomized requests checked against an arithmetic burst model.
module tb_simmem_burst_beat_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_id = '0;
    logic [18:0] in_addr = '0;
    logic [7:0]  in_len = '0;
    logic [2:0]  in_size = '0;
    logic [1:0]  in_burst = '0;
    logic        beat_valid;
    logic        beat_ready = 1'b0;
    logic [1:0]  beat_id;
    logic [18:0] beat_addr;
    logic [7:0]  beat_idx;
    logic        beat_last;
    logic        beat_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [18:0] exp_q[$];
    bit          exp_err;

    simmem_burst_beat_gen dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_id_i      (in_id),
        .in_addr_i    (in_addr),
        .in_len_i     (in_len),
        .in_size_i    (in_size),
        .in_burst_i   (in_burst),
        .beat_valid_o (beat_valid),
        .beat_ready_i (beat_ready),
        .beat_id_o    (beat_id),
        .beat_addr_o  (beat_addr),
        .beat_idx_o   (beat_idx),
        .beat_last_o  (beat_last),
        .beat_err_o   (beat_err)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beat addresses from the burst rules, using plain integer arithmetic.
    task automatic model(input logic [18:0] addr, input int len, input int size, input int burst);
        longint a     = longint'(addr);
        longint bytes = longint'(1) << size;
        longint total = longint'(len + 1) * bytes;
        longint al    = (a / bytes) * bytes;
        longint lower = (a / total) * total;
        longint v;
        bit e = 0;
        exp_q.delete();
        if (burst == 3) e = 1;
        if (size > 2) e = 1;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) e = 1;
        if (burst == 2 && (a % bytes) != 0) e = 1;
        if (burst == 0 && len > 15) e = 1;
        if (burst == 1 && (al / 4096) != ((al + total - 1) / 4096)) e = 1;
        exp_err = e;
        if (e) begin
            exp_q.push_back(addr);
            return;
        end
        for (int n = 0; n <= len; n++) begin
            if (burst == 0 || n == 0) v = a;
            else if (burst == 1) v = al + n * bytes;
            else v = lower + ((a - lower) + n * bytes) % total;
            exp_q.push_back(19'(v));
        end
    endtask

    // Drive one request from posedge+1; returns at posedge+1 of the acceptance cycle's successor.
    task automatic send_req(input logic [1:0] id, input logic [18:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        in_valid = 1'b1;
        in_id    = id;
        in_addr  = addr;
        in_len   = len;
        in_size  = size;
        in_burst = burst;
        check("req_ready", 32'(in_ready), 32'd1);
        check("idle_valid", 32'(beat_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic check_beat(input int n, input logic [1:0] id);
        int nb = exp_q.size();
        check("beat_valid", 32'(beat_valid), 32'd1);
        check("beat_addr", 32'(beat_addr), 32'(exp_q[n]));
        check("beat_idx", 32'(beat_idx), 32'(n));
        check("beat_last", 32'(beat_last), 32'(n == nb - 1));
        check("beat_err", 32'(beat_err), 32'(exp_err));
        check("beat_id", 32'(beat_id), 32'(id));
        check("busy_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic run_burst(input logic [1:0] id, input logic [18:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int stall_beat, input int stall_cycles, input bit rnd);
        int st;
        model(addr, int'(len), int'(size), int'(burst));
        send_req(id, addr, len, size, burst);
        for (int n = 0; n < exp_q.size(); n++) begin
            st = 0;
            if (n == stall_beat) st = stall_cycles;
            else if (rnd && ($urandom % 4 == 0)) st = int'($urandom % 3);
            for (int s = 0; s <= st; s++) begin
                beat_ready = (s == st);
                check_beat(n, id);
                @(posedge clk); #1;
            end
        end
        beat_ready = 1'b0;
        check("post_valid", 32'(beat_valid), 32'd0);
        check("post_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  r_burst;
        logic [2:0]  r_size;
        logic [7:0]  r_len;
        logic [18:0] r_addr;
        int          pick;

        // Reset state
        #1;
        check("rst_valid", 32'(beat_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_addr", 32'(beat_addr), 32'd0);
        check("rst_id", 32'(beat_id), 32'd0);
        check("rst_idx", 32'(beat_idx), 32'd0);
        check("rst_last", 32'(beat_last), 32'd0);
        check("rst_err", 32'(beat_err), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed bursts from the test plan
        run_burst(2'd1, 19'h00104, 8'd3, 3'd2, 2'd1, -1, 0, 1'b0);
        run_burst(2'd2, 19'h00102, 8'd2, 3'd2, 2'd1, -1, 0, 1'b0);
        run_burst(2'd3, 19'h00038, 8'd3, 3'd2, 2'd2, -1, 0, 1'b0);
        run_burst(2'd0, 19'h0003A, 8'd3, 3'd2, 2'd2, -1, 0, 1'b0);
        run_burst(2'd1, 19'h00200, 8'd2, 3'd2, 2'd0, -1, 0, 1'b0);
        run_burst(2'd2, 19'h00FF8, 8'd3, 3'd2, 2'd1, -1, 0, 1'b0);
        run_burst(2'd3, 19'h00100, 8'd3, 3'd3, 2'd1, -1, 0, 1'b0);
        run_burst(2'd0, 19'h00100, 8'd3, 3'd2, 2'd3, -1, 0, 1'b0);
        run_burst(2'd1, 19'h00400, 8'd3, 3'd2, 2'd1, 1, 3, 1'b0);
        run_burst(2'd2, 19'h00000, 8'd255, 3'd2, 2'd1, 100, 2, 1'b0);
        run_burst(2'd3, 19'h7FFF0, 8'd0, 3'd0, 2'd2, -1, 0, 1'b0);
        run_burst(2'd0, 19'h7FFF0, 8'd3, 3'd2, 2'd1, -1, 0, 1'b0);
        run_burst(2'd1, 19'h7FFF4, 8'd3, 3'd2, 2'd1, -1, 0, 1'b0);

        // Reset asserted during beat 2 of a len 7 INCR
        model(19'h00800, 7, 2, 1);
        send_req(2'd2, 19'h00800, 8'd7, 3'd2, 2'd1);
        beat_ready = 1'b1;
        for (int n = 0; n < 2; n++) begin
            check_beat(n, 2'd2);
            @(posedge clk); #1;
        end
        check_beat(2, 2'd2);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(beat_valid), 32'd0);
        check("mid_rst_addr", 32'(beat_addr), 32'd0);
        check("mid_rst_idx", 32'(beat_idx), 32'd0);
        check("mid_rst_last", 32'(beat_last), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("after_rst_valid", 32'(beat_valid), 32'd0);
            check("after_rst_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        beat_ready = 1'b0;
        run_burst(2'd1, 19'h01234, 8'd0, 3'd1, 2'd1, -1, 0, 1'b0);

        // Randomized requests with random backpressure
        for (int k = 0; k < 200; k++) begin
            r_burst = 2'($urandom % 4);
            r_size  = 3'($urandom % 4);
            r_addr  = 19'($urandom);
            pick    = int'($urandom % 4);
            case (r_burst)
                2'd2: begin
                    case (pick)
                        0: r_len = 8'd1;
                        1: r_len = 8'd3;
                        2: r_len = 8'd7;
                        default: r_len = (($urandom % 2) == 0) ? 8'd15 : 8'($urandom % 20);
                    endcase
                    if (($urandom % 4) != 0)
                        r_addr = r_addr & ~((19'd1 << r_size) - 19'd1);
                end
                2'd0: r_len = 8'($urandom % 20);
                default: r_len = (pick == 0) ? 8'($urandom) : 8'($urandom % 16);
            endcase
            run_burst(2'($urandom), r_addr, r_len, r_size, r_burst, -1, 0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
